// File: rtl/cic_pkg.sv
// Shared CIC types and the shift-and-saturate helper used by the cic output stages.
package cic_pkg;
  localparam int IN_WIDTH  = 24;
  localparam int OUT_WIDTH = 16;

  typedef logic signed [OUT_WIDTH-1:0] sample_t;

  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  // Arithmetic right shift of an offset-removed word, clamped to the signed sample range.
  function automatic sample_t sat_shift(input logic signed [IN_WIDTH:0] x,
                                        input int unsigned sh);
    logic signed [IN_WIDTH:0] v;
    v = x >>> sh;
    if (v > SAT_MAX) return OUT_WIDTH'(SAT_MAX);
    if (v < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
    return OUT_WIDTH'(v);
  endfunction
endpackage

// File: rtl/cic_sample_fifo.sv
// First-word-fall-through sample FIFO; head shows the last popped word while empty.
module cic_sample_fifo
  import cic_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_push,
  input  sample_t                        i_data,
  input  logic                           i_pop,
  output sample_t                        o_head,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  sample_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  sample_t          r_last;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? r_last : r_mem[r_rd];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_last <= r_mem[r_rd];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/cic3_decim_out.sv
// CIC3 output stage: decimation strobe, offset removal, shift/saturate, sample FIFO.
module cic3_decim_out
  import cic_pkg::*;
#(
  parameter int DECIM      = 64,
  parameter int OFFSET     = 131072,
  parameter int SHIFT      = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [IN_WIDTH-1:0]               cic_in,
  output sample_t                           out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level,
  output logic                              overflow,
  input  logic                              clear_overflow
);
  localparam int PH_W = $clog2(DECIM);
  localparam logic [PH_W-1:0]          PH_LAST  = PH_W'(DECIM - 1);
  localparam logic signed [IN_WIDTH:0] OFFSET_S = (IN_WIDTH+1)'(OFFSET);

  logic [PH_W-1:0]          r_phase;
  logic                     w_strobe;
  logic signed [IN_WIDTH:0] r_s1;
  logic                     r_s1_vld;
  sample_t                  w_push_data;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_drop;

  assign w_strobe = enable && (r_phase == PH_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (!enable || r_phase == PH_LAST) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Stage 1 runs on the strobe only; stage 2 is the FIFO push, which ignores enable
  // so a sample already captured always completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_strobe;
      if (w_strobe) r_s1 <= $signed({1'b0, cic_in}) - OFFSET_S;
    end
  end

  assign w_push_data = sat_shift(r_s1, SHIFT);

  cic_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_s1_vld),
    .i_data  (w_push_data),
    .i_pop   (out_ready),
    .o_head  (out_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (fill_level)
  );

  assign out_valid = !w_empty;

  // Full implies valid, so a ready consumer always makes room for the incoming sample.
  assign w_drop = r_s1_vld && w_full && !out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (w_drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cic3_decim_out.sv
// Directed bench for cic3_decim_out with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_cic3_decim_out;
  localparam int DECIM  = 64;
  localparam int OFFSET = 131072;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] cic_in = 24'hFFFFFF;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  logic [15:0] out_data2;
  logic        out_valid2;
  logic [3:0]  fill_level2;
  logic        overflow2;

  int checks = 0;
  int failures = 0;

  always #100 clk = ~clk;

  cic3_decim_out dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cic_in(cic_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  cic3_decim_out #(.OFFSET(8388608)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cic_in(cic_in),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1),
    .fill_level(fill_level2), .overflow(overflow2), .clear_overflow(1'b0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Expected sample straight from the arithmetic: floor((x - offset) / 8), clamped to int16.
  function automatic int exp_sample(input int unsigned x, input int off);
    longint v;
    longint q;
    v = longint'(x) - longint'(off);
    if (v >= 0) q = v / 8;
    else        q = -((-v + 7) / 8);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  int m_q[$];
  int m_last = 0;
  bit m_ovf = 1'b0;
  bit m_p1_v = 1'b0;
  int m_p1_d = 0;
  int m_en_cnt = 0;

  always @(posedge clk or negedge reset_n) begin : model
    bit pop;
    bit push;
    bit drop;
    int pd;
    if (!reset_n) begin
      m_q.delete();
      m_last = 0;
      m_ovf = 1'b0;
      m_p1_v = 1'b0;
      m_p1_d = 0;
      m_en_cnt = 0;
    end else begin
      pop  = (m_q.size() > 0) && out_ready;
      push = m_p1_v;
      pd   = m_p1_d;
      if (enable) m_en_cnt++;
      else        m_en_cnt = 0;
      m_p1_v = enable && (m_en_cnt % DECIM == 0);
      if (m_p1_v) m_p1_d = exp_sample(int'(cic_in), OFFSET);
      drop = 1'b0;
      if (pop) m_last = m_q.pop_front();
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(pd);
        else                    drop = 1'b1;
      end
      if (drop)                m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmp_valid", int'(out_valid), int'(m_q.size() > 0));
    chk("cmp_fill", int'(fill_level), m_q.size());
    chk("cmp_ovf", int'(overflow), int'(m_ovf));
    chk("cmp_data", int'($signed(out_data)), (m_q.size() > 0) ? m_q[0] : m_last);
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 300);
    chk("wait_valid", int'(out_valid), 1);
  endtask

  initial begin
    int n;

    // Reset with a full-scale input present.
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_fill", int'(fill_level), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_fill", int'(fill_level), 0);

    // Midscale: first-sample latency and sample period.
    cic_in = 24'd131072;
    out_ready = 1'b1;
    enable = 1'b1;
    wait_valid(n);
    chk("first_latency", n, 65);
    chk("mid_data", int'($signed(out_data)), 0);
    wait_valid(n);
    chk("period", n, 64);

    // Full scale and saturation.
    @(negedge clk) cic_in = 24'd262143;
    wait_valid(n);
    chk("pos_full", int'($signed(out_data)), 16383);
    @(negedge clk) cic_in = 24'hFFFFFF;
    wait_valid(n);
    chk("pos_sat", int'($signed(out_data)), 32767);
    @(negedge clk) cic_in = 24'd0;
    wait_valid(n);
    chk("neg_full", int'($signed(out_data)), -16384);
    chk("neg_sat_valid", int'(out_valid2), 1);
    chk("neg_sat", int'($signed(out_data2)), -32768);

    // Nine ramp samples into a stalled consumer; the ninth is dropped.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk) cic_in = 24'(131072 + 800 * k);
      if (k == 0) begin
        @(negedge clk) out_ready = 1'b0;
        repeat (62) @(negedge clk);
      end else begin
        repeat (63) @(negedge clk);
      end
    end
    @(negedge clk) cic_in = 24'(131072 + 8000);
    repeat (2) @(negedge clk);
    chk("ovf_fill", int'(fill_level), 8);
    chk("ovf_set", int'(overflow), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_order", int'($signed(out_data)), 100 * k);
      @(negedge clk);
    end
    chk("drain_empty", int'(out_valid), 0);
    wait_valid(n);
    chk("after_drop", int'($signed(out_data)), 1000);
    chk("ovf_sticky", int'(overflow), 1);
    @(negedge clk) clear_overflow = 1'b1;
    @(negedge clk) clear_overflow = 1'b0;
    chk("ovf_clear", int'(overflow), 0);

    // Full FIFO with a pop on the same edge as a push.
    out_ready = 1'b0;
    cic_in = 24'(131072 + 56);
    n = 0;
    while (m_q.size() < DEPTH && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("refill", int'(fill_level), 8);
    n = 0;
    while (m_p1_v && n < 10) begin
      @(negedge clk);
      n++;
    end
    clear_overflow = 1'b1;
    @(negedge clk) clear_overflow = 1'b0;
    n = 0;
    while (!m_p1_v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_p1_v) timeout_fail("push_wait");
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    chk("popush_fill", int'(fill_level), 8);
    chk("popush_ovf", int'(overflow), 0);

    // Reset while a sample sits in stage 1.
    n = 0;
    while (!m_p1_v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_p1_v) timeout_fail("stage1_wait");
    reset_n = 1'b0;
    cic_in = 24'(131072 + 40);
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_fill", int'(fill_level), 0);
    chk("midrst_ovf", int'(overflow), 0);
    chk("midrst_data", int'(out_data), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    wait_valid(n);
    chk("postrst_latency", n, 65);
    chk("postrst_data", int'($signed(out_data)), 5);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
